stall_control_param: RTL
========================

Name: stall_control_param

Overview:
- Parametrised successor to the fixed LD/Jump/HLT stall logic. It decodes the opcode field of the instruction presented by program memory and drives the pipeline stall.
- Stall length per instruction class is a parameter. HALT is sticky until a resume pulse. An external stall request (memory wait) freezes the controller.
- Sits between program memory and the fetch/decode stage. It drives `stall` (combinational, to decode) and `stall_pm` (registered, to the PC/program memory).

Parameters:
- INS_W, 20, instruction width
- OPC_W, 5, opcode field width
- OPC_LSB, 15, bit position of opcode LSB within ins_pm (field = ins_pm[OPC_LSB+OPC_W-1:OPC_LSB])
- OPC_HLT, 5'b10001, exact HALT opcode
- OPC_LD, 5'b10100, exact LOAD opcode
- JMP_MASK, 5'b11100, jump decode mask
- JMP_MATCH, 5'b11100, jump hit when (opc & JMP_MASK) == JMP_MATCH
- LD_STALL, 1, stall cycles for LOAD (0 = no stall)
- JMP_STALL, 2, stall cycles for jump class (0 = no stall)
- CNT_W, 4, counter width; LD_STALL and JMP_STALL must be <= 2^CNT_W

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ins_pm  in  INS_W  instruction from program memory
- ext_stall_req  in  1  external stall request (memory wait), level
- resume  in  1  one-cycle pulse that releases HALT
- stall  out  1  combinational stall to the pipeline
- stall_pm  out  1  stall delayed one clk, to the PC/program memory
- halted  out  1  registered, high while in HALTED
- stall_class  out  2  registered class being serviced: 0 none, 1 LD, 2 JMP, 3 HLT

Behaviour:
- Decode: opc from ins_pm. Priority is HLT > JMP > LD; the lower class is ignored on overlap. Decode is acted on only in IDLE.
- FSM states:
  - IDLE:
    - HLT hit -> stall=1, next HALTED.
    - JMP hit with JMP_STALL>0 -> stall=1, cnt<=JMP_STALL-1, next WAIT if JMP_STALL>1, else RELEASE.
    - LD hit: same as JMP, using LD_STALL.
    - Class with 0 stall cycles -> no stall, stay IDLE.
  - WAIT: stall=1, decode ignored. cnt decrements each cycle. When cnt==1 and decrementing, next RELEASE (cnt reaches 0).
  - RELEASE: stall=0, decode ignored for exactly one cycle so the held instruction is not re-triggered; next IDLE.
  - HALTED: stall=1, decode ignored. resume=1 -> next RELEASE. resume outside HALTED is ignored.
- Stall length: total asserted cycles including the detect cycle = LD_STALL or JMP_STALL. Default LD gives 1 cycle, jump gives 2, HLT is held until resume.
- ext_stall_req:
  - stall = fsm_stall | ext_stall_req.
  - While ext_stall_req=1, the FSM and counter hold (no transition, no decrement). IDLE decode still drives stall but the state does not advance until the request drops.
- stall_pm: registered copy of stall; reset 0.
- stall_class: updated with the state. It is held through WAIT/HALTED and cleared on entry to RELEASE/IDLE.
- Reset (reset=0, async):
  - state IDLE, cnt 0, stall_pm 0, halted 0, stall_class 0.
  - stall is forced 0 while reset is low. Reset mid-WAIT or mid-HALTED aborts immediately.
- Simultaneous events:
  - resume together with ext_stall_req in HALTED: the resume is lost, HALTED persists. Software must re-pulse resume.
  - HLT arriving in RELEASE is ignored (consumed as the held instruction).
- Counter saturates at 0 and never wraps.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - state enum (IDLE, WAIT, RELEASE, HALTED)
  - stall_class encoding
  - default opcode constants OPC_HLT, OPC_LD, JMP_MASK, JMP_MATCH
- One sub-module, stall_down_counter (load, enable, zero flag; CNT_W wide).
- Decode and FSM stay in the top module.

Test Plan:
- LD, defaults: ins_pm=20'hA0000 held 2 cycles then 20'h00000 -> stall high 1 cycle, stall_pm high the following cycle, stall_class=1 for 0 cycles after the edge (LD_STALL=1 goes straight to RELEASE), no retrigger.
- Jump: ins_pm=20'hE0000 held 3 cycles -> stall high 2 cycles then low; stall_pm mirrors delayed by 1. Repeat with JMP_STALL=4 -> 4 cycles.
- HALT: ins_pm=20'h88000 -> stall and halted stay 1 for 10 cycles; resume pulse -> stall 0 on the next cycle, halted 0, one RELEASE cycle, then new LD detected normally.
- ext_stall_req: raise it during the 2nd jump stall cycle for 3 cycles -> stall stays 1 throughout, and the counter resumes so total jump stall = 2 + 3 cycles.
- Reset: assert reset low mid-WAIT and mid-HALTED asynchronously -> all outputs 0 immediately (before the next clk edge); after release with ins_pm=20'h00000, stall=0.
- Zero config: LD_STALL=0, ins_pm=20'hA0000 -> stall never asserts and stall_class stays 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default opcode constants for the pipeline stall controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_HALTED  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_LD   = 2'd1,
        CLS_JMP  = 2'd2,
        CLS_HLT  = 2'd3
    } stall_class_e;

    localparam logic [4:0] OPC_HLT   = 5'b10001;
    localparam logic [4:0] OPC_LD    = 5'b10100;
    localparam logic [4:0] JMP_MASK  = 5'b11100;
    localparam logic [4:0] JMP_MATCH = 5'b11100;

endpackage

// File: rtl/stall_control_param_if.sv
// Program-memory / pipeline side signals of the stall controller.
interface stall_control_param_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int INS_W = 20
);
    logic [INS_W-1:0] ins_pm;
    logic             ext_stall_req;
    logic             resume;
    logic             stall;
    logic             stall_pm;
    logic             halted;
    stall_class_e     stall_class;

    modport master (
        output ins_pm, ext_stall_req, resume,
        input  stall, stall_pm, halted, stall_class
    );

    modport slave (
        input  ins_pm, ext_stall_req, resume,
        output stall, stall_pm, halted, stall_class
    );
endinterface

// File: rtl/stall_down_counter.sv
// Loadable down-counter that saturates at zero; load wins over enable.
module stall_down_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_q;

    // Load a new stall length, otherwise decrement toward zero and stick there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (enable && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);
endmodule

// File: rtl/stall_control_param.sv
// Opcode-driven pipeline stall controller with configurable stall lengths,
// sticky HALT and external stall freeze.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | decode active; a stalling class asserts stall this cycle
//  WAIT    | remaining stall cycles counted down, decode ignored
//  RELEASE | stall low for one cycle, held instruction not re-decoded
//  HALTED  | stall held until resume (ignored while ext_stall_req)
module stall_control_param
    import pipeline_ctrl_pkg::*;
#(
    parameter int               INS_W     = 20,
    parameter int               OPC_W     = 5,
    parameter int               OPC_LSB   = 15,
    parameter logic [OPC_W-1:0] OPC_HLT   = pipeline_ctrl_pkg::OPC_HLT,
    parameter logic [OPC_W-1:0] OPC_LD    = pipeline_ctrl_pkg::OPC_LD,
    parameter logic [OPC_W-1:0] JMP_MASK  = pipeline_ctrl_pkg::JMP_MASK,
    parameter logic [OPC_W-1:0] JMP_MATCH = pipeline_ctrl_pkg::JMP_MATCH,
    parameter int               LD_STALL  = 1,
    parameter int               JMP_STALL = 2,
    parameter int               CNT_W     = 4
) (
    input logic                  clk,
    input logic                  reset,
    stall_control_param_if.slave bus
);
    // The detect cycle is the first stall cycle, so the counter holds the remainder.
    localparam bit               LD_EN     = (LD_STALL > 0);
    localparam bit               JMP_EN    = (JMP_STALL > 0);
    localparam bit               LD_MULTI  = (LD_STALL > 1);
    localparam bit               JMP_MULTI = (JMP_STALL > 1);
    localparam logic [CNT_W-1:0] LD_LOAD   = LD_EN  ? CNT_W'(LD_STALL - 1)  : '0;
    localparam logic [CNT_W-1:0] JMP_LOAD  = JMP_EN ? CNT_W'(JMP_STALL - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state, state_next;
    stall_class_e     class_q, class_next;
    logic [INS_W-1:0] ins;
    logic [OPC_W-1:0] opc;
    logic             hit_hlt, hit_jmp, hit_ld;
    logic             unused_ins;
    logic             cnt_load, cnt_en, cnt_zero;
    logic [CNT_W-1:0] cnt_val, cnt;
    logic             fsm_stall;
    logic             stall_pm_q, halted_q;

    assign ins        = bus.ins_pm;
    assign opc        = ins[OPC_LSB +: OPC_W];
    assign unused_ins = ^ins;

    // HLT outranks jump, jump outranks load.
    assign hit_hlt = (opc == OPC_HLT);
    assign hit_jmp = !hit_hlt && ((opc & JMP_MASK) == JMP_MATCH);
    assign hit_ld  = !hit_hlt && !hit_jmp && (opc == OPC_LD);

    stall_down_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .enable   (cnt_en),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, counter control and class tracking; all frozen by ext_stall_req.
    always_comb begin
        state_next = state;
        class_next = class_q;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_en     = 1'b0;
        if (!bus.ext_stall_req) begin
            case (state)
                ST_IDLE: begin
                    class_next = CLS_NONE;
                    if (hit_hlt) begin
                        state_next = ST_HALTED;
                        class_next = CLS_HLT;
                    end else if (hit_jmp && JMP_EN) begin
                        cnt_load = 1'b1;
                        cnt_val  = JMP_LOAD;
                        if (JMP_MULTI) begin
                            state_next = ST_WAIT;
                            class_next = CLS_JMP;
                        end else begin
                            state_next = ST_RELEASE;
                        end
                    end else if (hit_ld && LD_EN) begin
                        cnt_load = 1'b1;
                        cnt_val  = LD_LOAD;
                        if (LD_MULTI) begin
                            state_next = ST_WAIT;
                            class_next = CLS_LD;
                        end else begin
                            state_next = ST_RELEASE;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_en = 1'b1;
                    if ((cnt == CNT_ONE) || cnt_zero) begin
                        state_next = ST_RELEASE;
                        class_next = CLS_NONE;
                    end
                end
                ST_RELEASE: begin
                    state_next = ST_IDLE;
                    class_next = CLS_NONE;
                end
                ST_HALTED: begin
                    if (bus.resume) begin
                        state_next = ST_RELEASE;
                        class_next = CLS_NONE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    class_next = CLS_NONE;
                end
            endcase
        end
    end

    // FSM stall output: immediate on decode in IDLE, held in WAIT/HALTED.
    always_comb begin
        fsm_stall = 1'b0;
        case (state)
            ST_IDLE:    fsm_stall = hit_hlt || (hit_jmp && JMP_EN) || (hit_ld && LD_EN);
            ST_WAIT:    fsm_stall = 1'b1;
            ST_HALTED:  fsm_stall = 1'b1;
            default:    fsm_stall = 1'b0;
        endcase
    end

    // Reset gates stall so an instruction held on ins_pm cannot leak through.
    assign bus.stall = reset & (fsm_stall | bus.ext_stall_req);

    // Registered status outputs track the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_pm_q <= 1'b0;
            halted_q   <= 1'b0;
            class_q    <= CLS_NONE;
        end else begin
            stall_pm_q <= bus.stall;
            halted_q   <= (state_next == ST_HALTED);
            class_q    <= class_next;
        end
    end

    assign bus.stall_pm    = stall_pm_q;
    assign bus.halted      = halted_q;
    assign bus.stall_class = class_q;
endmodule
